// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcode classes,
// RV32I major opcodes and datapath mux selects.
package ctrl_pkg;

  localparam int unsigned OPC_W = 7;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic       ALU_A_RS1 = 1'b0;
  localparam logic       ALU_A_PC  = 1'b1;

  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd1;
  localparam logic [1:0] ALU_OP_CMP   = 2'd2;

endpackage

// File: rtl/op_decode.sv
// Maps an RV32I major opcode to the instruction class the control FSM sequences on.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_OP:     op_class = CLS_OP;
      OPC_OP_IMM: op_class = CLS_OP_IMM;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_LUI:    op_class = CLS_LUI;
      OPC_AUIPC:  op_class = CLS_AUIPC;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables and mux selects from state plus decoded opcode.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_instr,
  output logic        ir_enable,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_retired,
  output logic        illegal
);

  state_e    state;
  state_e    state_next;
  op_class_e op_class;
  logic      active;
  logic      unused_instr_bits;

  op_decode u_op_decode (
    .opcode   (instr[OPC_W-1:0]),
    .op_class (op_class)
  );

  assign unused_instr_bits = ^instr[31:OPC_W];

  // active keeps the first cycle after reset release quiet before fetching
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel_instr = 1'b0;
    ir_enable     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_PLUS4;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    alu_src_a     = ALU_A_RS1;
    alu_src_b     = ALU_B_RS2;
    alu_op        = ALU_OP_ADD;
    instr_retired = 1'b0;
    illegal       = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req       = 1'b1;
        mem_sel_instr = 1'b1;
        if (mem_ready) begin
          ir_enable  = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_class == CLS_ILLEGAL) begin
          if (TRAP_ON_ILLEGAL) begin
            state_next = ST_TRAP;
          end else begin
            instr_retired = 1'b1;
            state_next    = ST_FETCH;
          end
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_next = ST_WRITEBACK;
        case (op_class)
          CLS_OP: alu_op = ALU_OP_FUNCT;
          CLS_OP_IMM: begin
            alu_src_b = ALU_B_IMM;
            alu_op    = ALU_OP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b  = ALU_B_IMM;
            state_next = ST_MEMORY;
          end
          CLS_AUIPC: begin
            alu_src_a = ALU_A_PC;
            alu_src_b = ALU_B_IMM;
          end
          CLS_BRANCH: begin
            alu_op        = ALU_OP_CMP;
            instr_retired = 1'b1;
            state_next    = ST_FETCH;
            if (branch_taken) begin
              pc_write = 1'b1;
              pc_src   = PC_ALU;
            end
          end
          CLS_JAL: begin
            alu_src_a = ALU_A_PC;
            alu_src_b = ALU_B_IMM;
            pc_write  = 1'b1;
            pc_src    = PC_ALU;
          end
          CLS_JALR: begin
            alu_src_b = ALU_B_IMM;
            pc_write  = 1'b1;
            pc_src    = PC_JALR;
          end
          default: state_next = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = (op_class == CLS_STORE);
        if (mem_ready) begin
          if (op_class == CLS_STORE) begin
            instr_retired = 1'b1;
            state_next    = ST_FETCH;
          end else begin
            state_next = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        rf_we         = 1'b1;
        instr_retired = 1'b1;
        state_next    = ST_FETCH;
        case (op_class)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_LINK;
          CLS_LUI:           wb_sel = WB_IMM;
          default:           wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: illegal = 1'b1;
      default: state_next = ST_FETCH;
    endcase

    // Outputs are silent while reset is held and for the release cycle
    if (!(rst_n && active)) begin
      state_next    = ST_FETCH;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_sel_instr = 1'b0;
      ir_enable     = 1'b0;
      pc_write      = 1'b0;
      pc_src        = PC_PLUS4;
      rf_we         = 1'b0;
      wb_sel        = WB_ALU;
      alu_src_a     = ALU_A_RS1;
      alu_src_b     = ALU_B_RS2;
      alu_op        = ALU_OP_ADD;
      instr_retired = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed and random instructions checked cycle by cycle
// against a timeline model built from class latencies and memory wait counts.
module tb_control_fsm;

  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_LD    = 7'h03;
  localparam logic [6:0] OPC_ST    = 7'h23;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;

  localparam int K_OP = 0, K_OPI = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;

  logic       t_mem_req, t_mem_we, t_mem_sel_instr, t_ir_enable, t_pc_write;
  logic [1:0] t_pc_src, t_wb_sel, t_alu_src_b, t_alu_op;
  logic       t_rf_we, t_alu_src_a, t_instr_retired, t_illegal;
  logic       n_mem_req, n_mem_we, n_mem_sel_instr, n_ir_enable, n_pc_write;
  logic [1:0] n_pc_src, n_wb_sel, n_alu_src_b, n_alu_op;
  logic       n_rf_we, n_alu_src_a, n_instr_retired, n_illegal;

  logic [16:0] obs_t, obs_n;
  logic [6:0]  opc_tbl [9];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_sel_instr(t_mem_sel_instr), .ir_enable(t_ir_enable), .pc_write(t_pc_write),
    .pc_src(t_pc_src), .rf_we(t_rf_we), .wb_sel(t_wb_sel), .alu_src_a(t_alu_src_a),
    .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .instr_retired(t_instr_retired),
    .illegal(t_illegal)
  );

  control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(n_mem_req), .mem_we(n_mem_we),
    .mem_sel_instr(n_mem_sel_instr), .ir_enable(n_ir_enable), .pc_write(n_pc_write),
    .pc_src(n_pc_src), .rf_we(n_rf_we), .wb_sel(n_wb_sel), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .instr_retired(n_instr_retired),
    .illegal(n_illegal)
  );

  assign obs_t = {t_mem_req, t_mem_we, t_mem_sel_instr, t_ir_enable, t_pc_write, t_pc_src,
                  t_rf_we, t_wb_sel, t_alu_src_a, t_alu_src_b, t_alu_op, t_instr_retired, t_illegal};
  assign obs_n = {n_mem_req, n_mem_we, n_mem_sel_instr, n_ir_enable, n_pc_write, n_pc_src,
                  n_rf_we, n_wb_sel, n_alu_src_a, n_alu_src_b, n_alu_op, n_instr_retired, n_illegal};

  task automatic chk(input logic [31:0] observed, input logic [31:0] expected, input string tag);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int kind_of(input logic [6:0] opc);
    case (opc)
      OPC_R:     return K_OP;
      OPC_I:     return K_OPI;
      OPC_LD:    return K_LD;
      OPC_ST:    return K_ST;
      OPC_BR:    return K_BR;
      OPC_JAL:   return K_JAL;
      OPC_JALR:  return K_JALR;
      OPC_LUI:   return K_LUI;
      OPC_AUIPC: return K_AUIPC;
      default:   return K_ILL;
    endcase
  endfunction

  // {alu_src_a, alu_src_b, alu_op} expected during the execute cycle
  function automatic logic [4:0] exe_alu(input int k);
    case (k)
      K_OP:            return {1'b0, 2'd0, 2'd1};
      K_OPI:           return {1'b0, 2'd1, 2'd1};
      K_LD, K_ST:      return {1'b0, 2'd1, 2'd0};
      K_AUIPC, K_JAL:  return {1'b1, 2'd1, 2'd0};
      K_JALR:          return {1'b0, 2'd1, 2'd0};
      K_BR:            return {1'b0, 2'd0, 2'd2};
      default:         return 5'd0;
    endcase
  endfunction

  task automatic do_reset(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      chk(32'(obs_t), 32'd0, "reset_trap");
      chk(32'(obs_n), 32'd0, "reset_nop");
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk(32'(obs_t), 32'd0, "release_trap");
    chk(32'(obs_n), 32'd0, "release_nop");
  endtask

  // Runs one instruction from its first fetch cycle; fw/mw are wait cycles in fetch/memory
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input bit taken, input int abort_at, input string name);
    int k, len, ret_t, ret_n;
    bit ls, st, br, ill, has_wb;
    bit fetch, exe, mem, wb, fdone, mdone, last, pcw;
    logic [1:0] pcs, wbs;
    logic [4:0] alu;
    logic [16:0] exp_t, exp_n;
    logic [6:0] opc;
    opc = ins[6:0];
    k = kind_of(opc);
    ls = (k == K_LD) || (k == K_ST);
    st = (k == K_ST);
    br = (k == K_BR);
    ill = (k == K_ILL);
    has_wb = !(ill || br || st);
    len = ill ? fw + 2 : fw + 3 + (ls ? mw + 1 : 0) + (has_wb ? 1 : 0);
    ret_t = 0;
    ret_n = 0;
    for (int c = 0; c < len; c++) begin
      fetch = (c <= fw);
      fdone = (c == fw);
      exe = !ill && (c == fw + 2);
      mem = ls && (c >= fw + 3) && (c <= fw + 3 + mw);
      mdone = ls && (c == fw + 3 + mw);
      last = (c == len - 1);
      wb = has_wb && last;
      @(negedge clk);
      instr = ins;
      branch_taken = exe ? taken : 1'($urandom);
      mem_ready = (fdone || mdone) ? 1'b1 : (fetch || mem) ? 1'b0 : 1'($urandom);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk(32'(obs_t), 32'd0, $sformatf("%s abort_trap", name));
        chk(32'(obs_n), 32'd0, $sformatf("%s abort_nop", name));
        return;
      end
      #1;
      pcw = fdone || (exe && (k == K_JAL || k == K_JALR || (br && taken)));
      pcs = (exe && (k == K_JAL || (br && taken))) ? 2'd1 : (exe && k == K_JALR) ? 2'd2 : 2'd0;
      wbs = !wb ? 2'd0 : (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 :
            (k == K_LUI) ? 2'd3 : 2'd0;
      alu = exe ? exe_alu(k) : 5'd0;
      exp_t = {fetch || mem, mem && st, fetch, fdone, pcw, pcs, wb, wbs,
               alu[4], alu[3:2], alu[1:0], last && !ill, 1'b0};
      exp_n = exp_t;
      exp_n[1] = last;
      chk(32'(obs_t), 32'(exp_t), $sformatf("%s cyc%0d trap", name, c));
      chk(32'(obs_n), 32'(exp_n), $sformatf("%s cyc%0d nop", name, c));
      ret_t += int'(t_instr_retired);
      ret_n += int'(n_instr_retired);
    end
    chk(32'(ret_t), ill ? 32'd0 : 32'd1, $sformatf("%s retire_count_trap", name));
    chk(32'(ret_n), 32'd1, $sformatf("%s retire_count_nop", name));
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      instr = $urandom;
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      chk(32'(obs_t), 32'd1, $sformatf("trap_hold cyc%0d", i));
    end
  endtask

  task automatic run_random(input string name);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opc_tbl[$urandom_range(0, 8)];
    run_instr(r, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), -1, name);
  endtask

  initial begin
    opc_tbl = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    rst_n = 1'b0;
    instr = 32'd0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;

    do_reset(3);
    run_instr(32'h00208133, 0, 0, 1'b0, -1, "add");
    run_instr(32'h0000A103, 0, 2, 1'b0, -1, "lw_wait2");
    run_instr(32'h00208463, 0, 0, 1'b1, -1, "beq_taken");
    run_instr(32'h00208463, 0, 0, 1'b0, -1, "beq_not_taken");
    run_instr(32'h000000EF, 0, 0, 1'b0, -1, "jal");
    run_instr(32'h000080E7, 1, 0, 1'b0, -1, "jalr_fwait");
    run_instr(32'h123450B7, 0, 0, 1'b0, -1, "lui");
    run_instr(32'h0020A023, 2, 1, 1'b0, -1, "sw");

    for (int i = 0; i < 30; i++) run_random($sformatf("rand%0d", i));

    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, -1, "illegal_ff");
    trap_hold(20);
    do_reset(2);

    run_instr(32'h0000000B, 1, 0, 1'b0, -1, "illegal_custom");
    trap_hold(3);
    do_reset(1);

    run_instr(32'h0020A023, 1, 3, 1'b0, 5, "sw_reset_mid_wait");
    do_reset(1);
    run_instr(32'h00208133, 2, 0, 1'b0, -1, "add_after_reset");
    for (int i = 0; i < 8; i++) run_random($sformatf("tail%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
